// File: rtl/mem_pkg.sv
// Shared definitions for the RAM request/acknowledge controller.
package mem_pkg;

    localparam int DATA_W    = 14;
    localparam int ADDR_W    = 12;
    localparam int MEM_DEPTH = 144;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } gnt_t;

endpackage

// File: rtl/mem_arbiter_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter.
// o_gnt is one-hot: bit 0 = fetch port, bit 1 = data port.
module rr_arb2
    import mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic       i_req_if,
    input  logic       i_req_d,
    output logic [1:0] o_gnt
);

    gnt_t       r_last;
    logic [1:0] w_gnt;

    // A tie goes to whichever port was not granted last.
    always_comb begin
        w_gnt = '0;
        if (i_req_if && i_req_d) begin
            w_gnt = (r_last == GNT_D) ? 2'b01 : 2'b10;
        end else if (i_req_if) begin
            w_gnt = 2'b01;
        end else if (i_req_d) begin
            w_gnt = 2'b10;
        end
        o_gnt = w_gnt;
    end

    // Remember the last granted port; reset favours the fetch port on the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= GNT_D;
        end else if (i_en && (|w_gnt)) begin
            r_last <= w_gnt[1] ? GNT_D : GNT_IF;
        end
    end

endmodule

// File: rtl/mem_arbiter_ctrl.sv
// Fetch/data port arbiter in front of a single-port RAM.
// One access per three cycles: IDLE (grant/latch), ACCESS (RAM pins active),
// RESP (one-cycle ack). Out-of-range addresses skip ACCESS and ack with err.
module mem_arbiter_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_W    = mem_pkg::DATA_W,
    parameter int ADDR_W    = mem_pkg::ADDR_W,
    parameter int MEM_DEPTH = mem_pkg::MEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              d_err,
    output logic [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_wren,
    output logic              ram_rden,
    input  logic [DATA_W-1:0] ram_q
);

    state_t            r_state;
    state_t            w_next;
    gnt_t              r_gnt;
    logic              r_we;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    logic [1:0]        w_gnt;
    logic              w_arb_en;
    logic              w_start;
    logic              w_sel_d;
    logic [ADDR_W-1:0] w_addr;
    logic              w_oor;

    assign w_arb_en = (r_state == IDLE);

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_en     (w_arb_en),
        .i_req_if (if_req),
        .i_req_d  (d_req),
        .o_gnt    (w_gnt)
    );

    // Select the granted port's address and range-check it.
    always_comb begin
        w_start = |w_gnt;
        w_sel_d = w_gnt[1];
        w_addr  = w_sel_d ? d_addr : if_addr;
        w_oor   = (32'(w_addr) >= 32'(MEM_DEPTH));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state; requests are only looked at in IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next = w_oor ? RESP : ACCESS;
            ACCESS:  w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Outputs decoded from state and latched registers only.
    always_comb begin
        ram_address = r_addr;
        ram_data    = r_wdata;
        ram_wren    = (r_state == ACCESS) && r_we && !rst;
        ram_rden    = (r_state == ACCESS) && !r_we;
        if_ack      = (r_state == RESP) && (r_gnt == GNT_IF);
        d_ack       = (r_state == RESP) && (r_gnt == GNT_D);
        if_err      = if_ack && r_err;
        d_err       = d_ack && r_err;
        if_rdata    = r_if_rdata;
        d_rdata     = r_d_rdata;
    end

    // Request latch in IDLE, read-data capture at the end of ACCESS.
    // A write or an error completion zeroes the granted port's rdata.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt      <= GNT_IF;
            r_we       <= 1'b0;
            r_err      <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_gnt   <= w_sel_d ? GNT_D : GNT_IF;
                        r_addr  <= w_addr;
                        r_we    <= w_sel_d && d_we;
                        r_wdata <= w_sel_d ? d_wdata : '0;
                        r_err   <= w_oor;
                        if (w_oor) begin
                            if (w_sel_d) r_d_rdata  <= '0;
                            else         r_if_rdata <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (r_gnt == GNT_D) r_d_rdata  <= r_we ? '0 : ram_q;
                    else                r_if_rdata <= r_we ? '0 : ram_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Directed bench for mem_arbiter_ctrl with a behavioural RAM model.
module tb_mem_arbiter_ctrl;

    localparam int DW    = 14;
    localparam int AW    = 12;
    localparam int DEPTH = 144;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ack, if_err;
    logic          d_req, d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ack, d_err;
    logic [DW-1:0] ram_data;
    logic [AW-1:0] ram_address;
    logic          ram_wren, ram_rden;
    logic [DW-1:0] ram_q;

    int n_checks = 0;
    int n_err    = 0;
    logic [DW-1:0] exp_if_last, exp_d_last;

    mem_arbiter_ctrl #(.DATA_W(DW), .ADDR_W(AW), .MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
        .ram_data(ram_data), .ram_address(ram_address), .ram_wren(ram_wren),
        .ram_rden(ram_rden), .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    // RAM model: async read while rden; a recognisable junk pattern otherwise
    // stands in for the undriven bus so a stray capture shows up.
    logic [DW-1:0] mem [0:DEPTH-1];
    logic          tb_preload;

    assign ram_q = (ram_rden && ram_address < AW'(DEPTH)) ? mem[ram_address] : 14'h3EEE;

    always @(posedge clk) begin
        if (tb_preload) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            mem[12'h000] <= 14'h1234;
            mem[12'h001] <= 14'h0155;
            mem[12'h002] <= 14'h02AA;
            mem[12'h020] <= 14'h0777;
            mem[12'h08F] <= 14'h0ABC;
        end else if (ram_wren && ram_address < AW'(DEPTH)) begin
            mem[ram_address] <= ram_data;
        end
    end

    typedef struct {
        logic          port;      // 0 = fetch, 1 = data
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_if_ack"}, if_ack, 0);
        check({tag, "_if_err"}, if_err, 0);
        check({tag, "_d_ack"}, d_ack, 0);
        check({tag, "_d_err"}, d_err, 0);
        check({tag, "_wren"}, ram_wren, 0);
        check({tag, "_rden"}, ram_rden, 0);
        check({tag, "_if_rdata"}, if_rdata, 0);
        check({tag, "_d_rdata"}, d_rdata, 0);
        check({tag, "_ram_data"}, ram_data, 0);
        check({tag, "_ram_addr"}, ram_address, 0);
    endtask

    // One transaction on one port, started from IDLE at a negedge.
    task automatic run_txn(input string tag, input vec_t v);
        int cyc = 0;
        int wr  = 0;
        int rd  = 0;
        bit got = 0;
        int exp_lat = v.exp_err ? 1 : 2;
        if (v.port) begin
            d_req = 1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            if_req = 1; if_addr = v.addr;
        end
        while (!got && cyc < 6) begin
            @(negedge clk);
            cyc++;
            if (ram_wren) begin
                wr++;
                check({tag, "_wr_addr"}, ram_address, v.addr);
                check({tag, "_wr_data"}, ram_data, v.wdata);
            end
            if (ram_rden) begin
                rd++;
                check({tag, "_rd_addr"}, ram_address, v.addr);
            end
            if (if_ack || d_ack) begin
                got = 1;
                check({tag, "_latency"}, cyc, exp_lat);
                check({tag, "_ack_port"}, {if_ack, d_ack}, v.port ? 2'b01 : 2'b10);
                if (v.port) begin
                    check({tag, "_d_err"}, d_err, v.exp_err);
                    check({tag, "_d_rdata"}, d_rdata, v.exp_rdata);
                    check({tag, "_if_rdata_hold"}, if_rdata, exp_if_last);
                    check({tag, "_if_err"}, if_err, 0);
                end else begin
                    check({tag, "_if_err"}, if_err, v.exp_err);
                    check({tag, "_if_rdata"}, if_rdata, v.exp_rdata);
                    check({tag, "_d_rdata_hold"}, d_rdata, exp_d_last);
                    check({tag, "_d_err"}, d_err, 0);
                end
                if_req = 0;
                d_req  = 0;
            end
        end
        if (!got) begin
            n_checks++;
            n_err++;
            $display("FAIL %s_timeout: no ack after %0d cycles, expected one", tag, cyc);
            if_req = 0;
            d_req  = 0;
        end
        if (v.port) exp_d_last = v.exp_rdata;
        else        exp_if_last = v.exp_rdata;
        check({tag, "_wren_cycles"}, wr, (!v.exp_err && v.we) ? 1 : 0);
        check({tag, "_rden_cycles"}, rd, (!v.exp_err && !v.we) ? 1 : 0);
        @(negedge clk);
        check({tag, "_post_ack"}, {if_ack, d_ack}, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_ack;
        int ack_cyc [4];
        logic ack_port [4];
        int rd_cnt;

        rst = 1; tb_preload = 1;
        if_req = 0; if_addr = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        exp_if_last = '0; exp_d_last = '0;

        vecs[0] = '{1'b1, 1'b1, 12'h010, 14'h2A5A, 14'h0000, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 12'h010, 14'h0000, 14'h2A5A, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 12'h000, 14'h0000, 14'h1234, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 12'h090, 14'h3FFF, 14'h0000, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 12'h08F, 14'h0000, 14'h0ABC, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 12'hFFF, 14'h0000, 14'h0000, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 12'h08F, 14'h0000, 14'h0ABC, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 12'h08F, 14'h1555, 14'h0000, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 12'h08F, 14'h0000, 14'h1555, 1'b0};

        repeat (3) @(negedge clk);
        tb_preload = 0;
        check_all_zero("reset");

        // Both ports requesting from reset: IF, D, IF, D, three cycles apart.
        rst = 0;
        if_req = 1; if_addr = 12'h001;
        d_req = 1; d_we = 0; d_addr = 12'h002;
        n_ack = 0;
        for (int c = 1; c <= 20 && n_ack < 4; c++) begin
            @(negedge clk);
            if (if_ack || d_ack) begin
                check("rr_single_ack", {if_ack, d_ack} == 2'b11, 0);
                ack_cyc[n_ack]  = c;
                ack_port[n_ack] = d_ack;
                if (d_ack) check("rr_d_rdata", d_rdata, 14'h02AA);
                else       check("rr_if_rdata", if_rdata, 14'h0155);
                n_ack++;
            end
        end
        if_req = 0; d_req = 0;
        check("rr_ack_count", n_ack, 4);
        for (int k = 0; k < n_ack; k++) begin
            check($sformatf("rr_port%0d", k), ack_port[k], k % 2);
            check($sformatf("rr_cycle%0d", k), ack_cyc[k], 2 + 3 * k);
        end
        @(negedge clk);
        exp_if_last = 14'h0155;
        exp_d_last  = 14'h02AA;

        for (int i = 0; i < 9; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i]);
        end

        // Fetch request held across its ack: a second identical access follows.
        if_req = 1; if_addr = 12'h000;
        n_ack = 0; rd_cnt = 0;
        for (int c = 1; c <= 12 && n_ack < 2; c++) begin
            @(negedge clk);
            if (ram_rden) begin
                rd_cnt++;
                check("hold_rd_addr", ram_address, 12'h000);
            end
            if (if_ack) begin
                check("hold_cycle", c, 2 + 3 * n_ack);
                check("hold_rdata", if_rdata, 14'h1234);
                check("hold_err", if_err, 0);
                n_ack++;
            end
        end
        if_req = 0;
        check("hold_ack_count", n_ack, 2);
        check("hold_rden_cycles", rd_cnt, 2);
        @(negedge clk);
        exp_if_last = 14'h1234;

        // Reset asserted during the ACCESS cycle of a write.
        d_req = 1; d_we = 1; d_addr = 12'h020; d_wdata = 14'h1111;
        @(negedge clk);
        check("abort_in_access_wren", ram_wren, 1);
        rst = 1; d_req = 0; d_we = 0;
        #1;
        check("abort_wren_gated", ram_wren, 0);
        @(negedge clk);
        check_all_zero("abort_reset");
        rst = 0;
        exp_if_last = '0; exp_d_last = '0;
        @(negedge clk);
        check("abort_no_ack1", {if_ack, d_ack}, 2'b00);
        @(negedge clk);
        check("abort_no_ack2", {if_ack, d_ack}, 2'b00);
        run_txn("abort_readback", '{1'b1, 1'b0, 12'h020, 14'h0000, 14'h0777, 1'b0});

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_ctrl.md
Name: mem_arbiter_ctrl

Overview:
- Two-port request/acknowledge controller sitting directly upstream of the single-port data RAM.
- Arbitrates between the instruction-fetch port (read-only) and the data port (read/write); drives the RAM's data/address/wren/rden pins from registers.
- Captures RAM read data and returns it with a one-cycle ack pulse.
- Rejects out-of-range addresses with an error flag instead of touching the RAM.

Parameters:
- DATA_W, 14, RAM word width.
- ADDR_W, 12, RAM address width.
- MEM_DEPTH, 144, number of implemented RAM words; valid addresses are 0..MEM_DEPTH-1.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request, held until if_ack.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetch read data, valid while if_ack=1.
- if_ack  out  1  one-cycle completion pulse for the fetch port.
- if_err  out  1  address out of range; valid with if_ack.
- d_req  in  1  data request, held until d_ack.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_rdata  out  DATA_W  data read data, valid while d_ack=1.
- d_ack  out  1  one-cycle completion pulse for the data port.
- d_err  out  1  address out of range; valid with d_ack.
- ram_data  out  DATA_W  to RAM data.
- ram_address  out  ADDR_W  to RAM address.
- ram_wren  out  1  to RAM wren.
- ram_rden  out  1  to RAM rden.
- ram_q  in  DATA_W  from RAM q (high-Z when RAM is not reading).

Behaviour:
- Reset:
  - State = IDLE; last_grant = DATA, so fetch wins the first tie.
  - All acks, errs, ram_wren and ram_rden = 0.
  - if_rdata, d_rdata, ram_data and ram_address = 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Samples requests at each edge.
  - If only one port requests, grant it. If both request, grant the port not in last_grant, then update last_grant.
  - Latch addr, we (forced 0 for fetch), wdata and grant into registers.
  - If addr >= MEM_DEPTH, set err_r=1 and go to RESP, skipping ACCESS. Otherwise go to ACCESS.
  - If neither port requests, stay in IDLE.
- ACCESS (exactly 1 cycle):
  - ram_address and ram_data come from the latched registers.
  - ram_wren = we_r and not rst; ram_rden = not we_r. Both are decoded from state only, never from inputs.
  - At the closing edge, a read captures ram_q into the granted port's rdata register; a write leaves rdata at 0. Then go to RESP.
- RESP (exactly 1 cycle):
  - The granted port's ack = 1 and err = err_r.
  - The non-granted port's ack and err stay 0.
  - Requests are not sampled in RESP. Next state is IDLE.
- Latency and throughput:
  - Request sampled at edge N; ack high in cycle N+2 (in range) or N+1 (out of range).
  - At most one access per 3 cycles.
- Outside ACCESS, ram_wren = ram_rden = 0 and ram_q is ignored; its high-Z value is never captured.
- A requester drops req in or after its ack cycle. A req still high in the IDLE cycle after the ack counts as a new request.
- rdata registers hold their value until the next completion on the same port.
- Err responses return rdata = 0 and never assert ram_wren or ram_rden.
- Reset mid-operation: with rst high in ACCESS, no RAM write occurs (wren gated), the pending ack is dropped, and the FSM returns to IDLE.
- Simultaneous new requests during RESP wait for IDLE. The round-robin pointer guarantees each port is served within 2 grants.

Decomposition:
- Shared package mem_pkg:
  - DATA_W = 14, ADDR_W = 12, MEM_DEPTH = 144.
  - State encoding IDLE/ACCESS/RESP.
  - Grant encoding GNT_IF/GNT_D.
- One natural sub-module: rr_arb2, a 2-requester round-robin arbiter holding last_grant. It takes the two reqs and an enable, and outputs a one-hot grant.
- FSM and datapath stay in mem_arbiter_ctrl.

Test Plan:
- Data write then read:
  - d_req, d_we=1, d_addr=0x010, d_wdata=0x2A5A → ram_wren high 1 cycle with address 0x010; d_ack 2 cycles after sampling; d_err=0.
  - Then read 0x010 → d_rdata=0x2A5A with d_ack.
- Fetch read from a preloaded word at 0x000 → ram_rden high only during ACCESS; if_rdata = the preloaded value with if_ack; d_ack stays 0.
- Both ports request continuously from reset (fetch 0x001, data read 0x002) → grants alternate IF, D, IF, D; acks spaced 3 cycles apart; no port starves.
- d_addr=0x090 (=144), write → d_ack plus d_err one cycle after sampling; ram_wren never asserted; d_rdata=0.
- Assert rst during the ACCESS cycle of a write to 0x020 (value 0x1111) → no RAM write; a later read of 0x020 returns the old value; no ack for the aborted request; all outputs 0 after reset.
- Fetch req held high across its ack → a second access is issued starting in the following IDLE cycle, with identical address and data returned.
